// File: rtl/axi_lite_cmd_arbiter.sv
// rtl/axi_lite_cmd_arbiter.sv - two-requester round-robin command arbiter/sequencer for an AXI-Lite master
module axi_lite_cmd_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        aclk,
    input  logic        areset_n,

    input  logic        req0_valid,
    input  logic        req0_write,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_wdata,
    input  logic [3:0]  req0_wstrb,
    output logic        req0_ready,
    output logic        req0_done,
    output logic [31:0] req0_rdata,
    output logic        req0_err,

    input  logic        req1_valid,
    input  logic        req1_write,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,
    input  logic [3:0]  req1_wstrb,
    output logic        req1_ready,
    output logic        req1_done,
    output logic [31:0] req1_rdata,
    output logic        req1_err,

    output logic        start_read,
    output logic        start_write,
    output logic [31:0] addr,
    output logic [31:0] data,
    output logic [3:0]  wstrb,

    input  logic        bvalid,
    input  logic        bready,
    input  logic [1:0]  bresp,
    input  logic        rvalid,
    input  logic        rready,
    input  logic [1:0]  rresp,
    input  logic [31:0] rdata_in,

    output logic [1:0]  grant,
    output logic        busy,
    output logic [15:0] timeout_cnt_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;   // 1 = req1 won the most recent accept
    logic [1:0]  grant_q, grant_d;
    logic        cmd_write_q, cmd_write_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] req0_rdata_q, req0_rdata_d;
    logic        req0_err_q, req0_err_d;
    logic [31:0] req1_rdata_q, req1_rdata_d;
    logic        req1_err_q, req1_err_d;

    logic        win0, win1, accept;
    logic        hs, resp_err, timed_out;
    logic [31:0] result_rdata;
    logic        result_err;

    // Round-robin pick: on contention the requester that did not win last time goes
    assign win0   = req0_valid & (~req1_valid | last_grant_q);
    assign win1   = req1_valid & (~req0_valid | ~last_grant_q);
    assign accept = (state_q == S_IDLE) & (win0 | win1);

    // Only the handshake matching the issued command type counts as completion
    assign hs        = cmd_write_q ? (bvalid & bready) : (rvalid & rready);
    assign resp_err  = cmd_write_q ? (bresp != 2'b00) : (rresp != 2'b00);
    assign timed_out = (cnt_q == TO_LAST);

    // State register
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; completion takes precedence over timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (hs || timed_out) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode: strobes and pulses are single-cycle by construction of the state sequence
    always_comb begin
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        start_read  = 1'b0;
        start_write = 1'b0;
        req0_done   = 1'b0;
        req1_done   = 1'b0;
        busy        = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                req0_ready = win0;
                req1_ready = win1;
            end
            S_ISSUE: begin
                start_write = cmd_write_q;
                start_read  = ~cmd_write_q;
            end
            S_DONE: begin
                req0_done = grant_q[0];
                req1_done = grant_q[1];
            end
            default: ;
        endcase
    end

    // Completion result: read data only for a clean read, error on bad resp or timeout
    always_comb begin
        result_rdata = 32'd0;
        result_err   = 1'b1;
        if (hs) begin
            result_err = resp_err;
            if (!cmd_write_q && rresp == 2'b00) begin
                result_rdata = rdata_in;
            end
        end
    end

    // Datapath next values: command capture on accept, WAIT counter, per-requester result
    always_comb begin
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        cmd_write_d  = cmd_write_q;
        addr_d       = addr_q;
        data_d       = data_q;
        wstrb_d      = wstrb_q;
        cnt_d        = cnt_q;
        req0_rdata_d = req0_rdata_q;
        req0_err_d   = req0_err_q;
        req1_rdata_d = req1_rdata_q;
        req1_err_d   = req1_err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    last_grant_d = win1;
                    grant_d      = {win1, win0};
                    cmd_write_d  = win1 ? req1_write : req0_write;
                    addr_d       = win1 ? req1_addr  : req0_addr;
                    data_d       = win1 ? req1_wdata : req0_wdata;
                    wstrb_d      = win1 ? req1_wstrb : req0_wstrb;
                end
            end
            S_ISSUE: begin
                cnt_d = 16'd0;
            end
            S_WAIT: begin
                if (hs || timed_out) begin
                    if (grant_q[1]) begin
                        req1_rdata_d = result_rdata;
                        req1_err_d   = result_err;
                    end else begin
                        req0_rdata_d = result_rdata;
                        req0_err_d   = result_err;
                    end
                end else if (cnt_q != 16'hFFFF) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DONE: begin
                grant_d = 2'b00;
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            last_grant_q <= 1'b1;
            grant_q      <= 2'b00;
            cmd_write_q  <= 1'b0;
            addr_q       <= 32'd0;
            data_q       <= 32'd0;
            wstrb_q      <= 4'd0;
            cnt_q        <= 16'd0;
            req0_rdata_q <= 32'd0;
            req0_err_q   <= 1'b0;
            req1_rdata_q <= 32'd0;
            req1_err_q   <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            cmd_write_q  <= cmd_write_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            wstrb_q      <= wstrb_d;
            cnt_q        <= cnt_d;
            req0_rdata_q <= req0_rdata_d;
            req0_err_q   <= req0_err_d;
            req1_rdata_q <= req1_rdata_d;
            req1_err_q   <= req1_err_d;
        end
    end

    assign addr            = addr_q;
    assign data            = data_q;
    assign wstrb           = wstrb_q;
    assign grant           = grant_q;
    assign timeout_cnt_dbg = cnt_q;
    assign req0_rdata      = req0_rdata_q;
    assign req0_err        = req0_err_q;
    assign req1_rdata      = req1_rdata_q;
    assign req1_err        = req1_err_q;

endmodule
